// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RMW   = 3'd2,
    S_STORE = 3'd3,
    S_RESP  = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know B/H/W; loads additionally allow BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select plus sign/zero extension.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [2:0]       funct3_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    // addr[0] is ignored for halves; misaligned halves are trapped upstream when enabled.
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store initiator with sub-word read-modify-write stores.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 2048
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [31:0]      dmem_addr_o,
  output logic [WIDTH-1:0] dmem_wdata_o,
  output logic             dmem_we_o,
  input  logic [WIDTH-1:0] dmem_rdata_i
);

  // Handshake: a request is taken when req_valid_i && req_ready_o at a posedge;
  // req_ready_o is high only in IDLE. rsp_valid_o is a one-cycle pulse the core must take.

  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  lsu_state_t       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      wlo_q, wlo_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic             misalign;
  logic             req_fault;
  logic             mem_phase;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                    ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_fault = (req_addr_i[31:2] >= DEPTH_W) ||
                     f3_illegal(req_we_i, req_funct3_i) || misalign;

  lsu_load_align #(.WIDTH(WIDTH)) u_align (
    .word_i    (dmem_rdata_i),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .data_o    (load_data)
  );

  always_comb begin
    merged = dmem_rdata_i;
    if (f3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wlo_q[7:0];
        2'd1:    merged[15:8]  = wlo_q[7:0];
        2'd2:    merged[23:16] = wlo_q[7:0];
        default: merged[31:24] = wlo_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wlo_q;
    end else begin
      merged[15:0] = wlo_q;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wlo_d   = wlo_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d   = req_we_i;
          f3_d   = req_funct3_i;
          addr_d = req_addr_i;
          wlo_d  = req_wdata_i[15:0];
          // Full store word parks here; RMW overwrites it with the merged word.
          data_d = req_wdata_i;
          err_d  = req_fault;
          if (req_fault)                state_d = S_RESP;
          else if (!req_we_i)           state_d = S_LOAD;
          else if (req_funct3_i == F3_W) state_d = S_STORE;
          else                          state_d = S_RMW;
        end
      end
      S_LOAD: begin
        data_d  = load_data;
        state_d = S_RESP;
      end
      S_RMW: begin
        data_d  = merged;
        state_d = S_STORE;
      end
      S_STORE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wlo_q   <= 16'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wlo_q   <= wlo_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign mem_phase    = (state_q == S_LOAD) || (state_q == S_RMW) || (state_q == S_STORE);
  assign req_ready_o  = (state_q == S_IDLE);
  // Reset gates the write strobe and response so nothing escapes during the reset cycle.
  assign dmem_we_o    = (state_q == S_STORE) && rstn_i;
  assign rsp_valid_o  = (state_q == S_RESP) && rstn_i;
  assign rsp_err_o    = rsp_valid_o && err_q;
  assign rsp_rdata_o  = (rsp_valid_o && !we_q && !err_q) ? data_q : '0;
  assign dmem_addr_o  = mem_phase ? {2'b00, addr_q[31:2]} : 32'd0;
  assign dmem_wdata_o = (state_q == S_STORE) ? data_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed plan items then randomized requests against a word-level memory model.
module tb_load_store_unit;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_we_o;
  logic [31:0] dmem_rdata_i;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          wr_count = 0;
  int          checks = 0;
  int          failures = 0;

  load_store_unit dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_rdata_i (dmem_rdata_i)
  );

  // clock / memory environment
  always #5 clk = ~clk;

  assign dmem_rdata_i = mem[dmem_addr_o[10:0]];

  always @(posedge clk) begin
    if (dmem_we_o) begin
      mem[dmem_addr_o[10:0]] <= dmem_wdata_o;
      wr_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // reference model, byte/offset arithmetic on whole words
  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic int acc_off(input logic [2:0] f3, input logic [31:0] addr);
    int sz = acc_size(f3);
    if (sz == 4) return 0;
    if (sz == 2) return int'(addr % 4) / 2 * 2;
    return int'(addr % 4);
  endfunction

  function automatic logic ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if ((addr / 4) >= DEPTH) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % acc_size(f3)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [31:0] addr);
    int sz = acc_size(f3);
    logic [31:0] v = word >> (8 * acc_off(f3, addr));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                            input logic [31:0] addr, input logic [31:0] wd);
    int sz = acc_size(f3);
    int sh = 8 * acc_off(f3, addr);
    logic [31:0] mask;
    if (sz == 4) return wd;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // driver: one request, then watch response timing, write strobe and busy behaviour
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        flt;
    logic [31:0] wi;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic        got_err;
    int          exp_lat, exp_wc, lat, wc, wr_at;
    flt     = ref_fault(we, f3, addr);
    wi      = addr / 4;
    exp_lat = flt ? 1 : ((!we || f3 == 3'b010) ? 2 : 3);
    exp_wc  = (flt || !we) ? 0 : exp_lat - 1;
    exp_rd  = (!flt && !we) ? ref_load(ref_mem[wi[10:0]], f3, addr) : 32'd0;
    if (!flt && we) ref_mem[wi[10:0]] = ref_store(ref_mem[wi[10:0]], f3, addr, wd);

    @(negedge clk);
    check({tag, " ready_idle"}, 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    @(posedge clk);
    #1;
    // keep offering junk while busy; none of it may be accepted
    req_we_i     = 1'($urandom_range(0, 1));
    req_funct3_i = 3'($urandom_range(0, 7));
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    lat = 0; wc = 0; wr_at = 0; got_rd = '0; got_err = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (dmem_we_o) begin
        wc++;
        wr_at = c;
      end
      if (rsp_valid_o) begin
        lat     = c;
        got_rd  = rsp_rdata_o;
        got_err = rsp_err_o;
        req_valid_i = 1'b0;
      end else begin
        check({tag, " busy_ready"}, 32'(req_ready_o), 32'd0);
        check({tag, " idle_rdata"}, rsp_rdata_o, 32'd0);
      end
    end
    req_valid_i = 1'b0;
    check({tag, " rsp_cycle"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, 32'(got_err), 32'(flt));
    check({tag, " rdata"}, got_rd, exp_rd);
    check({tag, " we_count"}, 32'(wc), (exp_wc != 0) ? 32'd1 : 32'd0);
    check({tag, " we_cycle"}, 32'(wr_at), 32'(exp_wc));
  endtask

  task automatic reset_dut(input int cycles);
    @(negedge clk);
    rstn_i = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
  endtask

  // mid-operation reset: reset lands at the edge that ends cycle `at_cycle`
  task automatic reset_during(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int at_cycle);
    int wr_before;
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    wr_before = wr_count;
    repeat (at_cycle) @(negedge clk);
    rstn_i = 1'b0;
    #1;
    check({tag, " we_in_reset"}, 32'(dmem_we_o), 32'd0);
    @(negedge clk);
    check({tag, " no_rsp"}, 32'(rsp_valid_o), 32'd0);
    check({tag, " we_after"}, 32'(dmem_we_o), 32'd0);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " ready_after"}, 32'(req_ready_o), 32'd1);
    check({tag, " no_rsp2"}, 32'(rsp_valid_o), 32'd0);
    check({tag, " no_write"}, 32'(wr_count), 32'(wr_before));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    rstn_i       = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'd0;
    req_addr_i   = 32'd0;
    req_wdata_i  = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
    mem[5] = 32'h8070_60F0; ref_mem[5] = 32'h8070_60F0;

    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 32'(req_ready_o), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst rdata", rsp_rdata_o, 32'd0);
    check("rst err", 32'(rsp_err_o), 32'd0);
    check("rst we", 32'(dmem_we_o), 32'd0);
    check("rst addr", dmem_addr_o, 32'd0);
    check("rst wdata", dmem_wdata_o, 32'd0);
    @(negedge clk);
    rstn_i = 1'b1;

    do_req("LB 0x14", 1'b0, 3'b000, 32'h14, 32'd0);
    do_req("LBU 0x14", 1'b0, 3'b100, 32'h14, 32'd0);
    do_req("LH 0x16", 1'b0, 3'b001, 32'h16, 32'd0);
    do_req("LHU 0x16", 1'b0, 3'b101, 32'h16, 32'd0);
    do_req("SB 0x15", 1'b1, 3'b000, 32'h15, 32'h0000_00AB);
    do_req("LW 0x14", 1'b0, 3'b010, 32'h14, 32'd0);
    check("word5 value", ref_mem[5], 32'h8070_ABF0);
    do_req("SW 0x1FFC", 1'b1, 3'b010, 32'h1FFC, 32'hDEAD_BEEF);
    do_req("LW 0x1FFC", 1'b0, 3'b010, 32'h1FFC, 32'd0);
    do_req("SW 0x2000", 1'b1, 3'b010, 32'h2000, 32'h1234_5678);
    do_req("LW 0x13", 1'b0, 3'b010, 32'h13, 32'd0);
    do_req("LD f3=011", 1'b0, 3'b011, 32'h10, 32'd0);
    do_req("ST f3=100", 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF);
    do_req("SH 0x16", 1'b1, 3'b001, 32'h16, 32'hCAFE_5A5A);
    do_req("LH 0x16 rb", 1'b0, 3'b001, 32'h16, 32'd0);

    reset_during("rst RMW SH", 3'b001, 32'h16, 32'h0000_7777, 1);
    reset_during("rst STORE SW", 3'b010, 32'h18, 32'h0BAD_F00D, 1);
    reset_during("rst STORE SB", 3'b000, 32'h19, 32'h0000_0066, 2);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       w = 32'(2048 + $urandom_range(0, 3));
        1:       w = $urandom >> 2;
        2, 3:    w = 32'(2040 + $urandom_range(0, 7));
        default: w = 32'($urandom_range(0, 15));
      endcase
      a = (w << 2) | 32'($urandom_range(0, 3));
      do_req($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             $urandom);
    end

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 24 || i >= DEPTH - 8) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the single-port data memory: accepts one load/store request at a time from the core's execute stage and drives the word-addressed data memory. It performs byte/half/word access sizing and sign or zero extension on loads. Sub-word stores are done as read-modify-write, because the memory only writes whole words. The unit sits between the core datapath and the data memory and returns one response per accepted request.

## Interface
- WIDTH, 32: data width; only 32 is supported.
- DEPTH_WORDS, 2048: memory depth in words. Word index = byte address >> 2.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request (high only in IDLE).
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  WIDTH  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle response pulse; the core must accept it.
- rsp_rdata_o  out  WIDTH  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  access fault (misaligned, out of range, or illegal funct3).
- dmem_addr_o  out  32  word index into the data memory, upper bits zero.
- dmem_wdata_o  out  WIDTH  full write word.
- dmem_we_o  out  1  write enable; the memory writes on the next posedge.
- dmem_rdata_i  in  WIDTH  memory read data; combinational from dmem_addr_o.

## Operation
- States: IDLE, LOAD, RMW, STORE, RESP.
- IDLE
  - req_ready_o=1.
  - A handshake (valid & ready) latches we, funct3, addr and wdata.
  - Faulting request → RESP with err=1. Memory is not touched.
  - Load → LOAD. SW → STORE. SB/SH → RMW.
- LOAD
  - Drive dmem_addr_o = addr[31:2].
  - Select the byte or half using addr[1:0], then extend: LB/LH sign-extend, LBU/LHU zero-extend.
  - Register the result → RESP.
- RMW
  - Drive the address and read dmem_rdata_i.
  - Replace the addressed byte lanes with the low bits of wdata (SB: lane addr[1:0]; SH: lanes addr[1]*2 and addr[1]*2+1).
  - Register the merged word → STORE.
- STORE
  - dmem_we_o=1.
  - dmem_wdata_o = merged word (SB/SH) or wdata (SW).
  - → RESP.
- RESP: rsp_valid_o=1 for exactly one cycle → IDLE.
- Faults:
  - Word index ≥ DEPTH_WORDS.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 > 010.
  - Misalignment, controlled by the macro in Configuration.
- dmem_we_o is high only in STORE and is forced low while rstn_i=0.
- dmem_addr_o holds the latched word index in LOAD, RMW and STORE, and is 0 otherwise.

## Timing
- Reset values: state IDLE; req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0.
- Cycle 0 is the handshake cycle. Response rsp_valid_o is high in:
  - Fault: cycle 1.
  - Load or SW: cycle 2.
  - SB/SH: cycle 3.
- SW writes at the end of cycle 1. SB/SH write at the end of cycle 2.
- No new request is accepted while busy. req_ready_o is low from cycle 1 through RESP. The next handshake is possible in the cycle after RESP.
- rsp_rdata_o and rsp_err_o are valid only while rsp_valid_o=1 and are 0 otherwise.
- Reset mid-operation, including in RMW or STORE:
  - Return to IDLE on that edge and drop the pending response.
  - No partial write is issued after reset is asserted.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misalignment faults. Half with addr[0]=1, or word with addr[1:0]≠0, gives rsp_err_o=1 with no memory access.
- Not defined:
  - Misalignment is never a fault.
  - Word accesses ignore addr[1:0].
  - Half accesses ignore addr[0].
  - Range and funct3 faults still apply.

## Structure
- Package lsu_pkg:
  - lsu_state_t enum.
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- Sub-module lsu_load_align: combinational lane select and sign/zero extension from (word, addr[1:0], funct3).
- Store lane merge stays inline.

## Test plan
- After reset, memory word 5 = 0x8070_60F0. LB at byte address 0x14 → rsp in cycle 2, rdata=0xFFFF_FFF0, err=0. LBU at 0x14 → 0x0000_00F0.
- LH at 0x16 on the same word → 0xFFFF_8070. LHU at 0x16 → 0x0000_8070.
- SB wdata=0xAB at 0x15, then LW at 0x14 → word reads 0x8070_ABF0. dmem_we_o is high only in cycle 2; rsp arrives in cycle 3.
- SW 0xDEAD_BEEF at 0x1FFC → written to word 2047. SW at byte address 0x2000 → err=1 in cycle 1 and dmem_we_o never asserted.
- With LSU_MISALIGN_TRAP_EN, LW at 0x13 → err=1, no access. Without the macro, LW at 0x13 → returns word 4.
- Reset asserted during RMW of an SH → no write occurs, no rsp_valid_o pulse, req_ready_o=1 on the cycle after reset is released.
